// File: rtl/div_32_seq_pkg.sv
// div_32_seq_pkg: function-select codes and divider FSM state encoding.
package div_32_seq_pkg;
  localparam logic [4:0] FS_MUL  = 5'h1C;
  localparam logic [4:0] FS_MULU = 5'h1D;
  localparam logic [4:0] FS_DIV  = 5'h1E;
  localparam logic [4:0] FS_DIVU = 5'h1F;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/div_32_seq_step.sv
// div_32_seq_step: one restoring shift-subtract iteration.
module div_32_seq_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] den,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);
  logic [32:0] shifted, diff;
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, den};
  assign rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_n   = {quo[30:0], ~diff[32]};
endmodule

// File: rtl/div_32_seq.sv
// div_32_seq: 32-bit sequential signed/unsigned divider, 34-cycle latency.
module div_32_seq
  import div_32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  FS,
  input  logic [31:0] S,
  input  logic [31:0] T,
  output logic [31:0] Y_hi,
  output logic [31:0] Y_lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);
  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] den, rem, quo, s_raw, rem_n, quo_n;
  logic        neg_q, neg_r, is_signed, go, dbz;
  assign is_signed = FS == FS_DIV;
  assign go  = start && (is_signed || FS == FS_DIVU) && (state == IDLE || state == DONE);
  assign dbz = den == 32'd0;
  div_32_seq_step u_step (
    .rem   (rem),
    .quo   (quo),
    .den   (den),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      den         <= '0;
      rem         <= '0;
      quo         <= '0;
      s_raw       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      Y_hi        <= '0;
      Y_lo        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          Y_lo        <= dbz ? 32'hFFFF_FFFF : (neg_q ? -quo : quo);
          Y_hi        <= dbz ? s_raw : (neg_r ? -rem : rem);
          div_by_zero <= dbz;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
          // DONE behaves like IDLE so back-to-back operations lose no cycle
          if (go) begin
            busy  <= 1'b1;
            s_raw <= S;
            quo   <= (is_signed && S[31]) ? -S : S;
            den   <= (is_signed && T[31]) ? -T : T;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= is_signed && (S[31] ^ T[31]);
            neg_r <= is_signed && S[31];
            state <= (T == 32'd0) ? FIX : CALC;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: directed self-checking bench for div_32_seq.
module tb_div_32_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  FS = 5'h1E;
  logic [31:0] S = '0, T = '0;
  logic [31:0] Y_hi, Y_lo;
  logic        busy, done, div_by_zero;
  int checks = 0, errors = 0;

  div_32_seq dut (
    .clk(clk), .reset(reset), .start(start), .FS(FS), .S(S), .T(T),
    .Y_hi(Y_hi), .Y_lo(Y_lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an operation and returns the number of edges until done is seen.
  // inject > 1 pulses a second start with other operands mid-operation.
  task automatic run(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                     input int inject, output int lat);
    @(negedge clk);
    start = 1'b1; FS = fs; S = s; T = t;
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      start = (k + 1 == inject);
      if (k + 1 == inject) begin S = 32'd50; T = 32'd5; end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
  endtask

  int lat, dones;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_hi", Y_hi, 0);
    check("rst_y_lo", Y_lo, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk); reset = 1'b0;

    run(5'h1E, 32'd100, 32'd7, 0, lat);
    check("100_7_lat", lat, 34);
    check("100_7_lo", Y_lo, 14);
    check("100_7_hi", Y_hi, 2);
    check("100_7_dbz", {31'd0, div_by_zero}, 0);
    check("100_7_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 0);

    run(5'h1E, 32'hFFFF_FFF9, 32'd2, 0, lat);
    check("m7_2_lo", Y_lo, 32'hFFFF_FFFD);
    check("m7_2_hi", Y_hi, 32'hFFFF_FFFF);
    run(5'h1E, 32'hFFFF_FF9C, 32'd7, 0, lat);
    check("m100_7_lo", Y_lo, 32'hFFFF_FFF2);
    check("m100_7_hi", Y_hi, 32'hFFFF_FFFE);
    run(5'h1E, 32'd100, 32'hFFFF_FFF9, 0, lat);
    check("100_m7_lo", Y_lo, 32'hFFFF_FFF2);
    check("100_m7_hi", Y_hi, 32'd2);
    run(5'h1F, 32'hFFFF_FFFF, 32'd2, 0, lat);
    check("u_max_2_lo", Y_lo, 32'h7FFF_FFFF);
    check("u_max_2_hi", Y_hi, 32'd1);
    run(5'h1E, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    check("ovf_lo", Y_lo, 32'h8000_0000);
    check("ovf_hi", Y_hi, 32'd0);
    check("ovf_dbz", {31'd0, div_by_zero}, 0);

    run(5'h1E, 32'h1234_5678, 32'd0, 0, lat);
    check("dbz_lat", lat, 2);
    check("dbz_lo", Y_lo, 32'hFFFF_FFFF);
    check("dbz_hi", Y_hi, 32'h1234_5678);
    check("dbz_flag", {31'd0, div_by_zero}, 1);

    // unsupported function code: ignored, results hold
    @(negedge clk);
    start = 1'b1; FS = 5'h1C; S = 32'd9; T = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_fs_busy", {31'd0, busy}, 0);
    check("bad_fs_done", {31'd0, done}, 0);
    check("hold_lo", Y_lo, 32'hFFFF_FFFF);
    check("hold_dbz", {31'd0, div_by_zero}, 1);

    run(5'h1E, 32'd100, 32'd7, 5, lat);
    check("busy_start_lat", lat, 34);
    check("busy_start_lo", Y_lo, 14);
    check("busy_start_hi", Y_hi, 2);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_second_done", dones, 0);

    // abort in the middle of CALC
    @(negedge clk);
    start = 1'b1; FS = 5'h1E; S = 32'd1000; T = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_lo", Y_lo, 0);
    check("abort_hi", Y_hi, 0);
    check("abort_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk); reset = 1'b0;
    run(5'h1E, 32'd50, 32'd5, 0, lat);
    check("post_rst_lat", lat, 34);
    check("post_rst_lo", Y_lo, 10);
    check("post_rst_hi", Y_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_32_seq.md
DIV_32_SEQ -- requirements
Module: DIV_32_SEQ

Interface
REQ-001 Parameter: none; width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 FS  input  5  function select: FS_DIV (5'h1E, signed) or FS_DIVU (5'h1F, unsigned).
REQ-006 S  input  32  dividend, captured on accepted start.
REQ-007 T  input  32  divisor, captured on accepted start.
REQ-008 Y_hi  output  32  remainder (registered).
REQ-009 Y_lo  output  32  quotient (registered).
REQ-010 busy  output  1  high from the edge after acceptance until done asserts.
REQ-011 done  output  1  one-cycle pulse when Y_hi/Y_lo are updated.
REQ-012 div_by_zero  output  1  registered with the result; high when T was zero.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-014 In IDLE, start=1 with FS in {FS_DIV, FS_DIVU} SHALL be accepted at edge N: capture S, T, FS; set busy; go to CALC, or to FIX if T==0.
REQ-015 start with any other FS value SHALL be ignored; the FSM stays in IDLE.
REQ-016 start while busy SHALL be ignored with no effect on the operation in progress.
REQ-017 For FS_DIV, operands SHALL be converted to magnitudes, with the quotient sign = sign(S) XOR sign(T) and the remainder sign = sign(S).
REQ-018 CALC SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (edges N+1..N+32), using a 6-bit iteration counter.
REQ-019 FIX (edge N+33) SHALL apply sign correction, load Y_hi/Y_lo/div_by_zero, and enter DONE; done=1 and busy=0 for the following cycle, then return to IDLE.
REQ-020 Normal latency: done high in the cycle after edge N+33; next start may be accepted on the edge ending the DONE cycle.
REQ-021 Divide by zero: FIX at edge N+1 SHALL load Y_lo=32'hFFFFFFFF, Y_hi=S, div_by_zero=1; done is high after edge N+1.
REQ-022 Signed overflow 32'h80000000 / 32'hFFFFFFFF SHALL yield Y_lo=32'h80000000, Y_hi=0, div_by_zero=0.
REQ-023 Y_hi, Y_lo and div_by_zero SHALL hold their last value until the next FIX.
REQ-024 Results SHALL satisfy S = Y_lo*T + Y_hi (mod 2^32), with |Y_hi| < |T|, for all nonzero T.

Reset
REQ-025 reset SHALL force IDLE, clear the counter and operand registers, and drive Y_hi=0, Y_lo=0, busy=0, done=0, div_by_zero=0 immediately, including mid-operation.
REQ-026 The first start after reset deassertion SHALL be accepted normally with no residue from an aborted operation.

Structure
REQ-027 The shared package SHALL hold FS_DIV/FS_DIVU codes (alongside the existing multiply FS codes) and the state encoding constants.
REQ-028 One combinational sub-module, DIV_32_STEP (one remainder/quotient shift-subtract iteration), SHALL be instantiated by the datapath.

Verification
REQ-029 FS_DIV, S=100, T=7 -> after 34 cycles done=1, Y_lo=14, Y_hi=2, div_by_zero=0.
REQ-030 FS_DIV, S=-7 (32'hFFFFFFF9), T=2 -> Y_lo=32'hFFFFFFFD, Y_hi=32'hFFFFFFFF; FS_DIVU, S=32'hFFFFFFFF, T=2 -> Y_lo=32'h7FFFFFFF, Y_hi=1.
REQ-031 FS_DIV, S=32'h80000000, T=32'hFFFFFFFF -> Y_lo=32'h80000000, Y_hi=0.
REQ-032 T=0, S=32'h12345678 -> done after 2 cycles, Y_lo=32'hFFFFFFFF, Y_hi=32'h12345678, div_by_zero=1.
REQ-033 start pulsed at cycle 5 of an operation with different operands -> first result unchanged and on time, no second done.
REQ-034 reset asserted at CALC cycle 10 -> outputs zero and busy=0 at once; a new start of 50/5 -> Y_lo=10, Y_hi=0 after 34 cycles.
